ex_mem_pipe: RTL and testbench

Elastic EX/MEM pipeline boundary. It captures the execute stage's results and presents them to the memory stage. The results are the control bundles MEM/WB, the branch target, the zero flag, the ALU result, the store data and the destination register. It replaces a plain flop bank with a two-entry skid buffer and valid/ready handshake, so a stalled memory stage back-pressures execute without losing an instruction. It also supports a flush that turns all held instructions into bubbles, used when the memory stage resolves a taken branch.

---
 rtl/ex_mem_pipe.sv | 120 ++++++++++++
 tb/tb_ex_mem_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX/MEM boundary as a two-entry skid buffer with valid/ready handshake.
// Head entry drives the memory stage; skid absorbs one extra while stalled.
module ex_mem_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             MEM,
  input  logic [1:0]             WB,
  input  logic [DATA_W-1:0]      branchAddr,
  input  logic                   zero,
  input  logic [DATA_W-1:0]      ALUres,
  input  logic [DATA_W-1:0]      writeData,
  input  logic [REG_W-1:0]       rd,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             MEM_out,
  output logic [1:0]             WB_out,
  output logic [DATA_W-1:0]      branchAddr_out,
  output logic                   zero_out,
  output logic [DATA_W-1:0]      ALUres_out,
  output logic [DATA_W-1:0]      writeData_out,
  output logic [REG_W-1:0]       rd_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [2:0]        mem;
    logic [1:0]        wb;
    logic [DATA_W-1:0] branch_addr;
    logic              zero;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  rd;
  } entry_t;

  entry_t in_ent;
  entry_t head;
  entry_t skid;
  logic   head_valid;
  logic   skid_valid;
  logic   accept;
  logic   pop;

  assign in_ent = '{
    mem:         MEM,
    wb:          WB,
    branch_addr: branchAddr,
    zero:        zero,
    alu_res:     ALUres,
    write_data:  writeData,
    rd:          rd
  };

  // in_ready depends only on registered state, never on out_ready
  assign in_ready  = ~skid_valid;
  assign out_valid = head_valid;
  assign accept    = in_valid & in_ready;
  assign pop       = head_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!head_valid) begin
      head_valid <= accept;
    end else if (pop) begin
      if (skid_valid) begin
        skid_valid <= 1'b0;
      end else begin
        head_valid <= accept;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload carries no reset; validity lives only in the valid bits
  always_ff @(posedge clk) begin
    if (!head_valid || (pop && !skid_valid)) begin
      if (accept) begin
        head <= in_ent;
      end
    end else if (pop && skid_valid) begin
      head <= skid;
    end
  end

  always_ff @(posedge clk) begin
    if (head_valid && !pop && accept) begin
      skid <= in_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (head_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Bubbles must never trigger memory access, branch or writeback
  assign MEM_out        = head_valid ? head.mem : 3'b000;
  assign WB_out         = head_valid ? head.wb  : 2'b00;
  assign branchAddr_out = head.branch_addr;
  assign zero_out       = head.zero;
  assign ALUres_out     = head.alu_res;
  assign writeData_out  = head.write_data;
  assign rd_out         = head.rd;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: stimulus pushes accepted entries,
// a negedge monitor pops and compares against a 2-deep FIFO model.
module tb_ex_mem_pipe;

  typedef struct packed {
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [31:0] br;
    logic        z;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  MEM;
  logic [1:0]  WB;
  logic [31:0] branchAddr;
  logic        zero;
  logic [31:0] ALUres;
  logic [31:0] writeData;
  logic [4:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  MEM_out;
  logic [1:0]  WB_out;
  logic [31:0] branchAddr_out;
  logic        zero_out;
  logic [31:0] ALUres_out;
  logic [31:0] writeData_out;
  logic [4:0]  rd_out;
  logic [3:0]  stall_cnt;

  ex_mem_pipe #(
    .DATA_W(32),
    .REG_W(5),
    .STALL_CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .MEM(MEM),
    .WB(WB),
    .branchAddr(branchAddr),
    .zero(zero),
    .ALUres(ALUres),
    .writeData(writeData),
    .rd(rd),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .MEM_out(MEM_out),
    .WB_out(WB_out),
    .branchAddr_out(branchAddr_out),
    .zero_out(zero_out),
    .ALUres_out(ALUres_out),
    .writeData_out(writeData_out),
    .rd_out(rd_out),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   errors = 0;
  ent_t q[$];
  int   exp_stall = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: DUT state reflects model after the last posedge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
      chk("stall_cnt", 128'(stall_cnt), 128'(exp_stall));
      if (out_valid && q.size() > 0) begin
        chk("MEM_out", 128'(MEM_out), 128'(q[0].mem));
        chk("WB_out", 128'(WB_out), 128'(q[0].wb));
        chk("branchAddr_out", 128'(branchAddr_out), 128'(q[0].br));
        chk("zero_out", 128'(zero_out), 128'(q[0].z));
        chk("ALUres_out", 128'(ALUres_out), 128'(q[0].alu));
        chk("writeData_out", 128'(writeData_out), 128'(q[0].wd));
        chk("rd_out", 128'(rd_out), 128'(q[0].rd));
      end
      if (!out_valid) begin
        chk("bubble_MEM", 128'(MEM_out), 128'd0);
        chk("bubble_WB", 128'(WB_out), 128'd0);
      end
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (rst_n && q.size() > 0 && !out_ready && exp_stall < 15)
        exp_stall++;
    end
  end

  function automatic ent_t mk_rand();
    ent_t e;
    e.mem = 3'($urandom);
    e.wb  = 2'($urandom);
    e.br  = $urandom;
    e.z   = 1'($urandom);
    e.alu = $urandom;
    e.wd  = $urandom;
    e.rd  = 5'($urandom);
    return e;
  endfunction

  function automatic ent_t mk_alu(input logic [31:0] a);
    ent_t e;
    e = mk_rand();
    e.alu = a;
    return e;
  endfunction

  // One clock: drive now, sample handshake at negedge, update model at posedge
  task automatic cyc(input logic v, input logic ordy, input logic fl,
                     input logic rst, input ent_t e, output bit acc);
    in_valid   = v;
    out_ready  = ordy;
    flush      = fl;
    rst_n      = rst;
    MEM        = e.mem;
    WB         = e.wb;
    branchAddr = e.br;
    zero       = e.z;
    ALUres     = e.alu;
    writeData  = e.wd;
    rd         = e.rd;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      exp_stall = 0;
    end else if (fl) begin
      q.delete();
    end else if (acc) begin
      q.push_back(e);
    end
    #1;
  endtask

  initial begin
    bit   acc;
    ent_t e;
    ent_t c;
    e = mk_rand();
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, e, acc);
    cyc(0, 0, 0, 0, e, acc);
    mon_en = 1;

    e = mk_alu(32'h10);
    e.rd = 5'd5;
    e.mem = 3'b010;
    e.wb = 2'b11;
    cyc(1, 1, 0, 1, e, acc);
    cyc(0, 1, 0, 1, mk_rand(), acc);
    cyc(0, 1, 0, 1, mk_rand(), acc);

    for (int i = 1; i <= 8; i++) cyc(1, 1, 0, 1, mk_alu(32'(i)), acc);
    cyc(0, 1, 0, 1, mk_rand(), acc);
    cyc(0, 1, 0, 1, mk_rand(), acc);

    cyc(0, 1, 0, 0, mk_rand(), acc);
    cyc(1, 0, 0, 1, mk_alu(32'hA), acc);
    cyc(1, 0, 0, 1, mk_alu(32'hB), acc);
    c = mk_alu(32'hC);
    cyc(1, 0, 0, 1, c, acc);
    chk("C_held", 128'(acc), 128'd0);
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) cyc(1, 1, 0, 1, c, acc);
    chk("C_accepted", 128'(acc), 128'd1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, mk_rand(), acc);

    cyc(1, 0, 0, 1, mk_alu(32'hA1), acc);
    cyc(1, 0, 0, 1, mk_alu(32'hB1), acc);
    cyc(1, 0, 1, 1, mk_alu(32'hC1), acc);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, mk_rand(), acc);

    cyc(1, 0, 0, 1, mk_rand(), acc);
    cyc(1, 0, 0, 1, mk_rand(), acc);
    cyc(1, 1, 1, 0, mk_rand(), acc);
    chk("rst_stall", 128'(stall_cnt), 128'd0);
    cyc(0, 1, 0, 1, mk_rand(), acc);

    cyc(1, 0, 0, 1, mk_rand(), acc);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, mk_rand(), acc);
    chk("stall_sat", 128'(stall_cnt), 128'd15);
    cyc(0, 0, 1, 1, mk_rand(), acc);
    chk("flush_keeps_cnt", 128'(stall_cnt), 128'd15);
    cyc(0, 1, 0, 0, mk_rand(), acc);

    for (int i = 0; i < 500; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 63) != 0),
          mk_rand(), acc);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++)
      cyc(0, 1, 0, 1, mk_rand(), acc);
    chk("drain", 128'(q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
